// File: rtl/enc_bit_serializer.sv
// Pops {data, size, start} words from the encoder FIFO, rebuilds code-block framing
// and streams each byte MSB-first to the turbo encoder under a valid/ready handshake.
module enc_bit_serializer #(
  parameter int K_SMALL_BYTES = 132,
  parameter int K_LARGE_BYTES = 768
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] q_enc_fifo,
  input  logic       empty_enc_fifo,
  output logic       rreq_enc_fifo,
  input  logic       enc_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       bit_sop,
  output logic       bit_eop,
  output logic       k_sel,
  output logic       err_frame
);

  localparam int DATA_W = 8;
  localparam int BC_W   = 10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_BLK = 1'b1
  } state_t;

  logic              pend_p0;
  logic [DATA_W+1:0] nxt_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] sh_p2;
  logic [2:0]        idx_p2;
  logic              vld_p2;
  logic              sop_p2;
  logic              eop_p2;
  state_t            state;
  logic [BC_W-1:0]   bc;

  logic              xfer;
  logic              last_xfer;
  logic              take;
  logic              w_start;
  logic              w_size;
  logic [DATA_W-1:0] w_data;
  logic              w_eop;
  logic              do_drop;
  logic              do_load;
  logic              early_start;
  logic [BC_W-1:0]   bc_inc;

  logic [DATA_W-1:0] sh_n;
  logic [2:0]        idx_n;
  logic              vld_n;
  logic              sop_n;
  logic              eop_n;

  // Index of the final byte of a block for a given size code.
  function automatic logic [BC_W-1:0] last_bc(input logic ksel);
    last_bc = ksel ? BC_W'(K_LARGE_BYTES - 1) : BC_W'(K_SMALL_BYTES - 1);
  endfunction

  // Stage p0: issue a read only when nothing is in flight and the prefetch slot is free.
  assign rreq_enc_fifo = !empty_enc_fifo && !pend_p0 && !vld_p1 && !reset;

  // Stage p1 -> p2 hand-off: framing decisions are made on the byte leaving nxt.
  assign xfer        = vld_p2 && enc_ready;
  assign last_xfer   = xfer && (idx_p2 == 3'd0);
  assign take        = vld_p1 && (!vld_p2 || last_xfer);
  assign w_start     = nxt_p1[0];
  assign w_size      = nxt_p1[1];
  assign w_data      = nxt_p1[DATA_W+1:2];
  assign bc_inc      = bc + 1'b1;
  assign w_eop       = w_start ? (last_bc(w_size) == '0) : (bc_inc == last_bc(k_sel));
  assign do_drop     = take && (state == ST_IDLE) && !w_start;
  assign do_load     = take && !do_drop;
  assign early_start = take && (state == ST_IN_BLK) && w_start;

  always_comb begin
    sh_n  = sh_p2;
    idx_n = idx_p2;
    vld_n = vld_p2;
    sop_n = sop_p2;
    eop_n = eop_p2;
    if (do_load) begin
      sh_n  = w_data;
      idx_n = 3'd7;
      vld_n = 1'b1;
      sop_n = w_start;
      eop_n = w_eop;
    end else if (last_xfer) begin
      vld_n = 1'b0;
    end else if (xfer) begin
      idx_n = idx_p2 - 3'd1;
    end
  end

  assign bit_valid = vld_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_p0   <= 1'b0;
      nxt_p1    <= '0;
      vld_p1    <= 1'b0;
      sh_p2     <= '0;
      idx_p2    <= '0;
      vld_p2    <= 1'b0;
      sop_p2    <= 1'b0;
      eop_p2    <= 1'b0;
      state     <= ST_IDLE;
      bc        <= '0;
      k_sel     <= 1'b0;
      err_frame <= 1'b0;
      bit_out   <= 1'b0;
      bit_sop   <= 1'b0;
      bit_eop   <= 1'b0;
    end else begin
      // Stage p0 -> p1: FIFO data is valid the cycle after the request.
      pend_p0 <= rreq_enc_fifo;
      if (pend_p0) begin
        nxt_p1 <= q_enc_fifo;
        vld_p1 <= 1'b1;
      end else if (take) begin
        vld_p1 <= 1'b0;
      end

      // Stage p2: shift register and its registered bit-level outputs.
      sh_p2   <= sh_n;
      idx_p2  <= idx_n;
      vld_p2  <= vld_n;
      sop_p2  <= sop_n;
      eop_p2  <= eop_n;
      bit_out <= vld_n && sh_n[idx_n];
      bit_sop <= vld_n && sop_n && (idx_n == 3'd7);
      bit_eop <= vld_n && eop_n && (idx_n == 3'd0);

      err_frame <= do_drop || early_start;
      if (do_load) begin
        if (w_start) begin
          // A start byte always opens a fresh block, even if one was in progress.
          k_sel <= w_size;
          bc    <= '0;
          state <= w_eop ? ST_IDLE : ST_IN_BLK;
        end else begin
          bc <= bc_inc;
          if (w_eop) begin
            state <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_enc_bit_serializer.sv
// Randomized bench for enc_bit_serializer: FIFO model, queue-based framing reference,
// per-bit stream comparison and per-scenario error/read accounting.
module tb_enc_bit_serializer;

  localparam int KS = 4;
  localparam int KL = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] q_enc_fifo = '0;
  logic       empty_enc_fifo = 1'b1;
  logic       rreq_enc_fifo;
  logic       enc_ready = 1'b1;
  logic       bit_out, bit_valid, bit_sop, bit_eop, k_sel, err_frame;

  always #5 clk = ~clk;

  enc_bit_serializer #(.K_SMALL_BYTES(KS), .K_LARGE_BYTES(KL)) dut (
    .clk(clk), .reset(reset), .q_enc_fifo(q_enc_fifo), .empty_enc_fifo(empty_enc_fifo),
    .rreq_enc_fifo(rreq_enc_fifo), .enc_ready(enc_ready), .bit_out(bit_out),
    .bit_valid(bit_valid), .bit_sop(bit_sop), .bit_eop(bit_eop), .k_sel(k_sel),
    .err_frame(err_frame)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Reference model: FIFO contents and expected {bit, sop, eop, k_sel} per transferred bit.
  logic [9:0] fq[$];
  logic [3:0] exq[$];
  bit m_inblk = 0;
  int m_bc = 0;
  bit m_k = 0;
  int m_err = 0;
  int n_words = 0;

  function automatic int kbytes(input bit k);
    return k ? KL : KS;
  endfunction

  task automatic model_byte(input logic [7:0] d, input bit sop, input bit eop, input bit k);
    for (int i = 7; i >= 0; i--)
      exq.push_back({d[i], sop && (i == 7), eop && (i == 0), k});
  endtask

  task automatic push_word(input logic [7:0] d, input bit sz, input bit st);
    fq.push_back({d, sz, st});
    n_words++;
    if (st) begin
      if (m_inblk) m_err++;
      m_k = sz;
      m_bc = 0;
      m_inblk = 1;
      model_byte(d, 1, 0, sz);
    end else if (!m_inblk) begin
      m_err++;
    end else begin
      m_bc++;
      model_byte(d, 0, m_bc == kbytes(m_k) - 1, m_k);
      if (m_bc == kbytes(m_k) - 1) m_inblk = 0;
    end
  endtask

  // Cycle bookkeeping and FIFO read capture on the active edge.
  int   cyc = 0;
  logic rd_pend = 1'b0;
  int   rreq_cyc_q[$];
  int   xfer_q[$];
  int   err_seen = 0;
  int   rdy_mode = 0;
  int   rdy_ph = 0;

  always @(posedge clk) begin
    rd_pend <= rreq_enc_fifo;
    if (rreq_enc_fifo) rreq_cyc_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  // FIFO response, ready drive and output checking away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_pend && fq.size() > 0) q_enc_fifo = fq.pop_front();
      empty_enc_fifo = (fq.size() == 0);
      case (rdy_mode)
        0: enc_ready = 1'b1;
        1: begin
          enc_ready = (rdy_ph == 0) || (rdy_ph == 3);
          rdy_ph = (rdy_ph + 1) % 4;
        end
        default: enc_ready = 1'($urandom_range(0, 1));
      endcase
      if (!reset) begin
        if (err_frame) err_seen++;
        if (bit_valid) begin
          if (exq.size() == 0) begin
            check("extra_bit", 32'(bit_valid), 0);
          end else begin
            check("bit", 32'({bit_out, bit_sop, bit_eop, k_sel}), 32'(exq[0]));
            if (enc_ready) begin
              void'(exq.pop_front());
              xfer_q.push_back(cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int b_rreq, b_xfer, b_err, b_merr, b_words;

  task automatic scn_begin();
    b_rreq  = rreq_cyc_q.size();
    b_xfer  = xfer_q.size();
    b_err   = err_seen;
    b_merr  = m_err;
    b_words = n_words;
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic scn_end(input string tag);
    for (int i = 0; i < 4000; i++) begin
      step();
      if (exq.size() == 0 && fq.size() == 0 && !bit_valid) break;
    end
    repeat (6) step();
    check({tag, "_drain"}, 32'(exq.size()), 0);
    check({tag, "_err"}, 32'(err_seen - b_err), 32'(m_err - b_merr));
    check({tag, "_rreq"}, 32'(rreq_cyc_q.size() - b_rreq), 32'(n_words - b_words));
  endtask

  logic [7:0] sd[10];

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check("reset_outs", 32'({bit_out, bit_valid, bit_sop, bit_eop, k_sel, err_frame}), 0);
    check("reset_rreq", 32'(rreq_enc_fifo), 0);
    reset = 1'b0;
    step();

    // Single small block: A5 then three FF bytes.
    scn_begin();
    rdy_mode = 0;
    push_word(8'hA5, 0, 1);
    for (int i = 0; i < 3; i++) push_word(8'hFF, 0, 0);
    scn_end("s1");
    check("s1_nbits", 32'(xfer_q.size() - b_xfer), 32);
    if (xfer_q.size() - b_xfer == 32 && rreq_cyc_q.size() > b_rreq) begin
      check("s1_latency", 32'(xfer_q[b_xfer] - rreq_cyc_q[b_rreq]), 3);
      check("s1_contig", 32'(xfer_q[b_xfer + 31] - xfer_q[b_xfer]), 31);
    end

    // Large block followed immediately by a small block.
    for (int i = 0; i < 10; i++) sd[i] = 8'($urandom);
    scn_begin();
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) push_word(sd[i], i < 6, (i == 0) || (i == 6));
    scn_end("s2");
    check("s2_nbits", 32'(xfer_q.size() - b_xfer), 80);
    if (xfer_q.size() - b_xfer == 80)
      check("s2_contig", 32'(xfer_q[b_xfer + 79] - xfer_q[b_xfer]), 79);

    // Same stream under a 1,0,0,1 ready pattern.
    scn_begin();
    rdy_ph = 0;
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) push_word(sd[i], i < 6, (i == 0) || (i == 6));
    scn_end("s3");
    check("s3_nbits", 32'(xfer_q.size() - b_xfer), 80);

    // Early start on the third byte of a small block.
    scn_begin();
    rdy_mode = 0;
    push_word(8'h3C, 0, 1);
    push_word(8'h81, 0, 0);
    push_word(8'hC3, 0, 1);
    for (int i = 0; i < 3; i++) push_word(8'($urandom), 0, 0);
    scn_end("s4");
    check("s4_nbits", 32'(xfer_q.size() - b_xfer), 48);

    // Orphan byte in idle, then a normal block.
    scn_begin();
    push_word(8'h5A, 0, 0);
    push_word(8'h96, 0, 1);
    for (int i = 0; i < 3; i++) push_word(8'($urandom), 0, 0);
    scn_end("s5");
    check("s5_nbits", 32'(xfer_q.size() - b_xfer), 32);

    // Random blocks, truncations, orphans, FIFO gaps and random ready.
    scn_begin();
    rdy_mode = 2;
    for (int b = 0; b < 12; b++) begin
      bit sz;
      int n;
      sz = 1'($urandom_range(0, 1));
      n = kbytes(sz);
      if (!m_inblk && $urandom_range(0, 3) == 0) push_word(8'($urandom), 0, 0);
      if (b < 11 && $urandom_range(0, 4) == 0) n = $urandom_range(1, n - 1);
      for (int i = 0; i < n; i++) begin
        push_word(8'($urandom), sz, i == 0);
        repeat ($urandom_range(0, 12)) step();
      end
    end
    scn_end("s6");

    // Reset mid-block, then a fresh block.
    scn_begin();
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) push_word(8'($urandom), 1, i == 0);
    for (int i = 0; i < 200; i++) begin
      step();
      if (xfer_q.size() - b_xfer >= 9) break;
    end
    check("s7_reach", 32'(xfer_q.size() - b_xfer >= 9), 1);
    reset = 1'b1;
    fq.delete();
    exq.delete();
    m_inblk = 0;
    #1;
    check("s7_rreq_in_reset", 32'(rreq_enc_fifo), 0);
    step();
    check("s7_outs", 32'({bit_out, bit_valid, bit_sop, bit_eop, k_sel, err_frame}), 0);
    check("s7_rreq_hold", 32'(rreq_enc_fifo), 0);
    reset = 1'b0;
    step();
    scn_begin();
    push_word(8'hE7, 0, 1);
    for (int i = 0; i < 3; i++) push_word(8'($urandom), 0, 0);
    scn_end("s7");
    check("s7_nbits", 32'(xfer_q.size() - b_xfer), 32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
